// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared state encoding and default sizing for the shared-register arbiter
package dff_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/dff.sv
// dff: single-bit register cell with asynchronous active-low clear
module dff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) q <= 1'b0;
        else       q <= d;
endmodule

// File: rtl/dff_bank_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting just after the last owner
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             valid,
    output logic [IW-1:0]    winner
);
    int            idx;
    logic [IW-1:0] idx_l;
    always_comb begin
        valid  = |req;
        winner = '0;
        idx    = 0;
        idx_l  = '0;
        // walk from farthest to nearest so the nearest candidate wins
        for (int k = N_REQ; k >= 1; k--) begin
            idx   = (int'(last) + k) % N_REQ;
            idx_l = IW'(idx);
            winner = req[idx_l] ? idx_l : winner;
        end
    end
endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin owner of a shared register with optional lock bursts
import dff_arb_pkg::*;
module dff_bank_arbiter #(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       q,
    output logic                    busy
);
    localparam int IW = $clog2(N_REQ);
    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]      own_q, own_d, last_q, last_d, winner;
    logic               valid, wr;
    logic [DATA_W-1:0]  wslice, q_d;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req    (req),
        .last   (last_q),
        .valid  (valid),
        .winner (winner)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        own_d   = own_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (valid) begin
                state_d = GRANT;
                own_d   = winner;
                gnt_d   = N_REQ'(1) << winner;
            end
            // a withdrawn request releases regardless of lock
            GRANT: if (req[own_q] && lock[own_q]) state_d = LOCKED;
                   else begin
                       state_d = IDLE;
                       gnt_d   = '0;
                       last_d  = own_q;
                   end
            LOCKED: if (!lock[own_q]) begin
                state_d = IDLE;
                gnt_d   = '0;
                last_d  = own_q;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            last_q  <= last_d;
        end

    assign busy   = state_q != IDLE;
    assign gnt    = gnt_q;
    assign ack    = busy ? (gnt_q & req) : '0;
    assign wr     = |ack;
    assign wslice = DATA_W'(wdata >> (int'(own_q) * DATA_W));
    assign q_d    = wr ? wslice : q;

    for (genvar i = 0; i < DATA_W; i++) begin : g_q
        dff u_dff (.clk(clk), .rstn(rstn), .d(q_d[i]), .q(q[i]));
    end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed scenarios checked against an ownership model every cycle
module tb_dff_bank_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req = '0, lock = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   q;
    logic           busy;
    int tests = 0, fails = 0;

    int         m_owner = -1;
    bit         m_locked = 1'b0;
    int         m_last = N - 1;
    logic [7:0] m_q = '0;

    dff_bank_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
        .clk(clk), .rstn(rstn), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_ack();
        return (m_owner >= 0 && req[m_owner]) ? N'(1) << m_owner : '0;
    endfunction

    // model: one owner at a time, chosen round-robin; owner writes whenever it requests
    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_owner = -1; m_locked = 1'b0; m_last = N - 1; m_q = '0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++)
                if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
            m_locked = 1'b0;
        end else begin
            if (req[m_owner]) m_q = wdata[m_owner*W +: W];
            if (!m_locked && req[m_owner] && lock[m_owner]) m_locked = 1'b1;
            else if (!m_locked || !lock[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_locked = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("model_gnt", 32'(gnt), 32'(m_owner >= 0 ? N'(1) << m_owner : N'(0)));
        chk("model_ack", 32'(ack), 32'(m_ack()));
        chk("model_busy", 32'(busy), 32'(m_owner >= 0));
        chk("model_q", 32'(q), 32'(m_q));
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    logic [7:0] fair_data [N] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int         fair_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        step(); step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_q", 32'(q), 0);
        rstn = 1'b1;
        step();
        req = 4'b0001; wdata[7:0] = 8'hA5;
        step();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_busy", 32'(busy), 1);
        step();
        chk("single_q", 32'(q), 32'hA5);
        chk("single_busy_off", 32'(busy), 0);
        req = '0;
        step();
        rstn = 1'b0; #3; rstn = 1'b1;
        step();
        for (int i = 0; i < N; i++) wdata[i*W +: W] = fair_data[i];
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("fair_gnt", 32'(gnt), 32'(1 << fair_order[k]));
            chk("fair_ack", 32'(ack), 32'(1 << fair_order[k]));
            step();
            chk("fair_q", 32'(q), 32'(fair_data[fair_order[k]]));
        end
        req = '0;
        step();
        req = 4'b0101; lock = 4'b0100; wdata[23:16] = 8'd1; wdata[7:0] = 8'h5A;
        step();
        chk("lock_gnt", 32'(gnt), 32'h4);
        for (int d = 1; d <= 4; d++) begin
            step();
            chk("lock_q", 32'(q), 32'(d));
            chk("lock_gnt_hold", 32'(gnt), d < 4 ? 32'h4 : 32'h0);
            wdata[23:16] = 8'(d + 1);
            if (d == 3) lock = '0;
        end
        req = 4'b0001;
        step();
        chk("after_lock_gnt0", 32'(gnt), 32'h1);
        step();
        chk("after_lock_q", 32'(q), 32'h5A);
        req = '0;
        step();
        req = 4'b0010; wdata[15:8] = 8'h77;
        step();
        chk("wd_gnt", 32'(gnt), 32'h2);
        req = '0; #1;
        chk("wd_ack", 32'(ack), 0);
        step();
        chk("wd_q", 32'(q), 32'h5A);
        chk("wd_busy", 32'(busy), 0);
        req = 4'b0011; wdata[7:0] = 8'hC3;
        step();
        chk("wd_next_gnt", 32'(gnt), 32'h1);
        step();
        chk("wd_next_q", 32'(q), 32'hC3);
        req = 4'b1000; lock = 4'b1000; wdata[31:24] = 8'h11;
        step();
        chk("rl_gnt", 32'(gnt), 32'h8);
        step();
        wdata[31:24] = 8'h22;
        step();
        chk("rl_q", 32'(q), 32'h22);
        rstn = 1'b0; #1;
        chk("rl_rst_gnt", 32'(gnt), 0);
        chk("rl_rst_ack", 32'(ack), 0);
        chk("rl_rst_busy", 32'(busy), 0);
        chk("rl_rst_q", 32'(q), 0);
        req = 4'b1001; lock = '0; wdata[7:0] = 8'h3C;
        step();
        rstn = 1'b1;
        step();
        chk("rl_after_gnt", 32'(gnt), 32'h1);
        step();
        chk("rl_after_q", 32'(q), 32'h3C);
        req = '0;
        step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dff_bank_arbiter.md
DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

Interface
REQ-001 Parameter N_REQ SHALL be: default 4; number of requesters sharing the register, 2..8.
REQ-002 Parameter DATA_W SHALL be: default 8; width of the shared register.
REQ-003 Port clk SHALL be: input, 1 bit; clock, all state updates on rising edge.
REQ-004 Port rstn SHALL be: input, 1 bit; reset, asynchronous, active-low.
REQ-005 Port req SHALL be: input, N_REQ bits; req[i] high = requester i wants to write.
REQ-006 Port lock SHALL be: input, N_REQ bits; lock[i] high = requester i keeps ownership after its first write.
REQ-007 Port wdata SHALL be: input, N_REQ*DATA_W bits; requester i data at [i*DATA_W +: DATA_W].
REQ-008 Port gnt SHALL be: output, N_REQ bits; registered, one-hot or zero; current owner.
REQ-009 Port ack SHALL be: output, N_REQ bits; combinational, ack = gnt & req while state is GRANT or LOCKED, else 0.
REQ-010 Port q SHALL be: output, DATA_W bits; shared register contents.
REQ-011 Port busy SHALL be: output, 1 bit; high when state is not IDLE.

Function
REQ-012 FSM states SHALL be: IDLE, GRANT, LOCKED.
REQ-013 IDLE, req == 0: SHALL stay in IDLE with gnt = 0.
REQ-014 IDLE, req != 0: SHALL select the winner by round-robin and move to GRANT with gnt = onehot(winner) at the next edge.
- Search order: from index (last+1) mod N_REQ upward, wrapping.
REQ-015 Write rule: at every edge where ack[g] = 1, q SHALL load wdata slice g; q SHALL hold otherwise.
REQ-016 Write latency SHALL be: req sampled at edge E0, gnt high at E0+, ack and write at edge E1, new q visible after E1. Minimum 2 cycles per unlocked write.
REQ-017 GRANT, lock[g] = 1 at the edge: SHALL go to LOCKED, gnt held.
REQ-018 GRANT, lock[g] = 0: SHALL go to IDLE, gnt cleared, last <= g.
REQ-019 GRANT, req[g] = 0 (requester withdrew): SHALL perform no write, clear gnt, set last <= g, and go to IDLE.
- lock[g] SHALL be ignored in this case.
REQ-020 LOCKED SHALL write at every edge where req[g] = 1 (one write per cycle) and hold with no write while req[g] = 0.
REQ-021 LOCKED, lock[g] = 0 at an edge: SHALL go to IDLE, clear gnt and set last <= g.
- A same-edge write SHALL still occur if req[g] = 1.
REQ-022 lock and req of non-owners SHALL have no effect while busy; those requests SHALL stay pending and need no latching.
REQ-023 Requester handshake: the requester SHALL hold req and wdata stable until it sees ack; the arbiter SHALL NOT rely on this for safety.

Reset
REQ-024 rstn low SHALL, asynchronously at any time including mid-GRANT or mid-LOCKED, force: state IDLE, gnt 0, ack 0, busy 0, q 0, last = N_REQ-1.
- last = N_REQ-1 makes requester 0 first priority after reset.
REQ-025 Release of rstn SHALL take effect at the first rising clk edge with rstn high; no write SHALL occur on that edge.

Structure
REQ-026 Package dff_arb_pkg SHALL hold the state enum (IDLE/GRANT/LOCKED) and the default N_REQ/DATA_W constants.
REQ-027 Round-robin selection SHALL be one combinational sub-module rr_pick with inputs req and last, and outputs valid and winner index.
REQ-028 The q register SHALL be built from DATA_W instances of the team dff cell, with d = write ? wdata_slice : q.

Verification
REQ-029 Reset then single request: req = 0001, wdata0 = 8'hA5 -> gnt = 0001 one cycle later; ack0 pulses one cycle; q = 8'hA5; busy high exactly 1 cycle.
REQ-030 Fairness: req = 1111 held, no lock, distinct data -> grant order 0,1,2,3,0; each ack one cycle; q updates every 2 cycles.
REQ-031 Lock burst: req2 and lock2 held 4 cycles with data 1,2,3,4, req0 held -> 4 consecutive acks to 2; q = 4; gnt0 only after lock2 drops.
REQ-032 Withdrawal: req1 dropped in its GRANT cycle -> no ack, q unchanged, FSM back in IDLE, next grant search starts at index 2.
REQ-033 Reset mid-LOCKED: rstn low during requester 3 burst -> gnt, ack, busy, q = 0 immediately, without waiting for a clock; after release req = 1001 -> grant to 0 first.
